dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory (combinational read, write on posedge clk).
- Port 0 is the pipeline MEM stage and has priority. Port 1 is a secondary master: debug/loader/DMA.
- Fixed priority to port 0 with a starvation guard that forces a grant to port 1.
- Also checks address alignment and range, suppresses illegal writes and flags errors.

Parameters:
- DATA_W, 32, data width of both ports and the memory
- ADDR_W, 32, byte-address width
- MEM_WORDS, 1000, memory depth in words; legal byte addresses are 0 .. 4*MEM_WORDS-1
- STARVE_LIMIT, 4, consecutive cycles port 1 may be denied before a forced grant (1..15)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- p0_req  in  1  pipeline access request, held until granted
- p0_we  in  1  pipeline write enable
- p0_addr  in  ADDR_W  pipeline byte address
- p0_wdata  in  DATA_W  pipeline write data
- p0_gnt  out  1  combinational grant; low stalls the pipeline
- p0_rdata  out  DATA_W  combinational read data, valid while p0_gnt=1 and p0_we=0
- p1_req  in  1  secondary request, held with stable fields until granted
- p1_we  in  1  secondary write enable
- p1_addr  in  ADDR_W  secondary byte address
- p1_wdata  in  DATA_W  secondary write data
- p1_gnt  out  1  combinational grant
- p1_rdata  out  DATA_W  registered read data
- p1_rvalid  out  1  one-cycle pulse, the cycle after a granted p1 read
- mem_A  out  ADDR_W  address to data memory
- mem_WD  out  DATA_W  write data to data memory
- mem_WE  out  1  write enable to data memory
- mem_RD  in  DATA_W  read data from data memory
- err  out  1  sticky error flag: misaligned or out-of-range access granted
- err_addr  out  ADDR_W  address of the first erroneous access

Behaviour:
- Reset values: state=P0_PRI, starve_cnt=0, p1_rdata=0, p1_rvalid=0, err=0, err_addr=0.
- When no grant is active, mem_A=0, mem_WD=0 and mem_WE=0.
- State P0_PRI:
  - Grant p0 if p0_req=1, else grant p1 if p1_req=1.
  - starve_cnt increments when p1_req=1 and p1 is not granted; it clears on any p1 grant or when p1_req=0.
  - When starve_cnt reaches STARVE_LIMIT-1 while p1 is still denied, go to P1_FORCED.
- State P1_FORCED:
  - Grant p1 unconditionally, even if p0_req=1 (p0_gnt=0, so the pipeline stalls one cycle).
  - Return to P0_PRI and clear starve_cnt.
  - If p1_req dropped meanwhile (protocol violation), return to P0_PRI with no grant that cycle.
- At most one grant per cycle; p0_gnt and p1_gnt are never both 1.
- The granted port's addr, wdata and we drive mem_A, mem_WD and mem_WE in the same cycle. A write commits at the next rising edge.
- Legality: an access is illegal if addr[1:0]!=0 or addr>=4*MEM_WORDS.
  - An illegal granted access still completes the handshake (gnt=1) but forces mem_WE=0.
  - Reads return 0: p0_rdata=0, or p1_rdata=0 on the next cycle.
  - On the first illegal grant after reset, err=1 and err_addr=addr. err stays 1 and err_addr holds until rst.
- p0 read latency is 0 cycles (p0_rdata=mem_RD when granted). p1 read latency is 1 cycle (p1_rdata<=mem_RD, p1_rvalid<=1).
- A p1 write produces no rvalid.
- Back-to-back p1 grants yield rvalid on consecutive cycles.
- Reset mid-operation: a write granted in the same cycle as rst=1 is suppressed (mem_WE=0 while rst). A pending p1_rvalid is cleared.
- STARVE_LIMIT=1 means p1 is forced every cycle after one denial, i.e. strict alternation under continuous contention.

Decomposition:
- Shared package (risc_pkg): arbiter state enum (P0_PRI, P1_FORCED) and the byte-to-word shift constant (2).
- One natural sub-module: dmem_addr_check, combinational legality check; addr in, illegal out; parameter MEM_WORDS.
- Grant logic, starvation counter and response register stay in dmem_arbiter.

Test Plan:
- Only p0 active:
  - p0 write addr=0x10, data=0xDEADBEEF -> p0_gnt=1, mem_WE=1, mem_A=0x10; memory word 4 = 0xDEADBEEF after the edge.
  - Following p0 read -> p0_rdata=0xDEADBEEF in the same cycle.
- Only p1 read addr=0x8, with memory word 2 preloaded to 0xA:
  - p1_gnt=1 in cycle N.
  - p1_rvalid=1 and p1_rdata=0x0000000A in cycle N+1; rvalid=0 in N+2.
- Contention, STARVE_LIMIT=4, p0_req and p1_req held high:
  - p0 granted for cycles 0-3, p1 forced in cycle 4 (p0_gnt=0).
  - Pattern repeats every 5 cycles.
- Misaligned p0 write addr=0x6:
  - p0_gnt=1, mem_WE=0, err=1, err_addr=0x6.
  - A later illegal p1 read addr=4000 leaves err_addr=0x6, and p1_rdata=0 the next cycle.
- rst=1 asserted in the cycle p1 is granted a write to 0x20:
  - mem_WE=0 and memory word 8 is unchanged.
  - Next cycle: p1_rvalid=0, state=P0_PRI, starve_cnt=0, err=0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package risc_pkg;

    typedef enum logic {
        P0_PRI    = 1'b0,
        P1_FORCED = 1'b1
    } arb_state_t;

    // Byte address to word index shift for 32-bit words.
    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational legality check for one byte address: word alignment and range.
module dmem_addr_check
    import risc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1000
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              illegal
);

    // One extra bit so the byte limit cannot wrap when the memory fills the address space.
    localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(MEM_WORDS) << WORD_SHIFT;

    logic misaligned;
    logic out_of_range;

    assign misaligned   = (addr[WORD_SHIFT-1:0] != '0);
    assign out_of_range = ({1'b0, addr} >= BYTE_LIMIT);
    assign illegal      = misaligned | out_of_range;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: fixed priority to the
// pipeline, starvation guard for the secondary master, legality check and sticky error.
module dmem_arbiter
    import risc_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int MEM_WORDS    = 1000,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    input  logic [DATA_W-1:0] mem_RD,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT - 1);

    arb_state_t        state_reg, state_next;
    logic [3:0]        starve_cnt_reg, starve_cnt_next;
    logic [DATA_W-1:0] p1_rdata_reg;
    logic              p1_rvalid_reg;
    logic              err_reg;
    logic [ADDR_W-1:0] err_addr_reg;

    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0]             illegal;
    logic                   gnt0, gnt1;
    logic                   grant_illegal;
    logic [ADDR_W-1:0]      grant_addr;
    logic [DATA_W-1:0]      grant_wdata;
    logic                   grant_we;

    assign req_addr[0] = p0_addr;
    assign req_addr[1] = p1_addr;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chk
            dmem_addr_check #(
                .ADDR_W    (ADDR_W),
                .MEM_WORDS (MEM_WORDS)
            ) u_chk (
                .addr    (req_addr[gi]),
                .illegal (illegal[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        gnt0            = 1'b0;
        gnt1            = 1'b0;
        case (state_reg)
            P0_PRI: begin
                if (p0_req) begin
                    gnt0 = 1'b1;
                end else if (p1_req) begin
                    gnt1 = 1'b1;
                end
                if (p1_req && !gnt1) begin
                    if (starve_cnt_reg == STARVE_MAX) begin
                        state_next      = P1_FORCED;
                        starve_cnt_next = 4'd0;
                    end else begin
                        starve_cnt_next = starve_cnt_reg + 4'd1;
                    end
                end else begin
                    starve_cnt_next = 4'd0;
                end
            end
            P1_FORCED: begin
                // A dropped p1_req here is a protocol violation; nobody gets the slot.
                gnt1            = p1_req;
                state_next      = P0_PRI;
                starve_cnt_next = 4'd0;
            end
            default: begin
                state_next      = P0_PRI;
                starve_cnt_next = 4'd0;
            end
        endcase
    end

    always_comb begin
        grant_addr    = '0;
        grant_wdata   = '0;
        grant_we      = 1'b0;
        grant_illegal = 1'b0;
        if (gnt0) begin
            grant_addr    = p0_addr;
            grant_wdata   = p0_wdata;
            grant_we      = p0_we;
            grant_illegal = illegal[0];
        end else if (gnt1) begin
            grant_addr    = p1_addr;
            grant_wdata   = p1_wdata;
            grant_we      = p1_we;
            grant_illegal = illegal[1];
        end
    end

    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign mem_A     = grant_addr;
    assign mem_WD    = grant_wdata;
    // Illegal writes and writes overlapping reset never reach the memory.
    assign mem_WE    = grant_we & ~grant_illegal & ~rst;
    assign p0_rdata  = (gnt0 && !illegal[0]) ? mem_RD : '0;
    assign p1_rdata  = p1_rdata_reg;
    assign p1_rvalid = p1_rvalid_reg;
    assign err       = err_reg;
    assign err_addr  = err_addr_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= P0_PRI;
            starve_cnt_reg <= 4'd0;
            p1_rdata_reg   <= '0;
            p1_rvalid_reg  <= 1'b0;
            err_reg        <= 1'b0;
            err_addr_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            p1_rvalid_reg  <= gnt1 & ~p1_we;
            if (gnt1 && !p1_we) begin
                p1_rdata_reg <= illegal[1] ? '0 : mem_RD;
            end
            if (!err_reg && grant_illegal) begin
                err_reg      <= 1'b1;
                err_addr_reg <= grant_addr;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of grants, memory contents and error flag.
module tb_dmem_arbiter;

    localparam int MEM_WORDS = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p1_gnt, p1_rvalid, mem_WE, err;
    logic [31:0] p0_rdata, p1_rdata, mem_A, mem_WD, mem_RD, err_addr;

    logic        d1_p0_gnt, d1_p1_gnt, d1_p1_rvalid, d1_mem_WE, d1_err;
    logic [31:0] d1_p0_rdata, d1_p1_rdata, d1_mem_A, d1_mem_WD, d1_err_addr;
    logic [31:0] zero_word = 32'd0;

    logic [31:0] env_mem [0:MEM_WORDS-1];
    logic        mem_clr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(MEM_WORDS), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD),
        .err(err), .err_addr(err_addr)
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_WORDS(MEM_WORDS), .STARVE_LIMIT(1)) dut1 (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(d1_p0_gnt), .p0_rdata(d1_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(d1_p1_gnt), .p1_rdata(d1_p1_rdata), .p1_rvalid(d1_p1_rvalid),
        .mem_A(d1_mem_A), .mem_WD(d1_mem_WD), .mem_WE(d1_mem_WE), .mem_RD(zero_word),
        .err(d1_err), .err_addr(d1_err_addr)
    );

    // Data memory: combinational read, write on the rising edge.
    always_comb begin
        mem_RD = 32'd0;
        if (mem_A < 32'(4 * MEM_WORDS)) mem_RD = env_mem[mem_A[11:2]];
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MEM_WORDS; i++) env_mem[i] <= 32'd0;
        end else if (mem_WE && mem_A < 32'(4 * MEM_WORDS)) begin
            env_mem[mem_A[11:2]] <= mem_WD;
        end
    end

    function automatic bit is_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'(4 * MEM_WORDS));
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(1023, 0)) << 2;
        if ($urandom_range(7, 0) == 0) a = a + 32'($urandom_range(3, 1));
        if ($urandom_range(15, 0) == 0) a = $urandom;
        return a;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_req = 1'b0;
        p1_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_clr = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        next_cycle();
        next_cycle();
        rst = 1'b0; mem_clr = 1'b0;
        #4;
        checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt got p0=%b p1=%b want 0 0", p0_gnt, p1_gnt); end
        checks++; if (mem_WE !== 1'b0 || mem_A !== 32'd0 || mem_WD !== 32'd0) begin failures++; $display("FAIL reset_mem got A=%h WD=%h WE=%b want 0", mem_A, mem_WD, mem_WE); end
        checks++; if (p1_rvalid !== 1'b0 || p1_rdata !== 32'd0) begin failures++; $display("FAIL reset_p1 got rvalid=%b rdata=%h want 0", p1_rvalid, p1_rdata); end
        checks++; if (err !== 1'b0 || err_addr !== 32'd0) begin failures++; $display("FAIL reset_err got err=%b addr=%h want 0", err, err_addr); end
        $display("reset: outputs idle");
        next_cycle();
    endtask

    task automatic test_p0_only();
        p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
        #4;
        checks++; if (p0_gnt !== 1'b1 || mem_WE !== 1'b1 || mem_A !== 32'h10) begin failures++; $display("FAIL p0_write got gnt=%b WE=%b A=%h want 1 1 10", p0_gnt, mem_WE, mem_A); end
        $display("p0 write addr=%h data=%h", p0_addr, p0_wdata);
        next_cycle();
        checks++; if (env_mem[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL p0_write_mem got %h want deadbeef", env_mem[4]); end
        p0_we = 0;
        #4;
        checks++; if (p0_gnt !== 1'b1 || p0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL p0_read got gnt=%b rdata=%h want 1 deadbeef", p0_gnt, p0_rdata); end
        $display("p0 read addr=%h data=%h", p0_addr, p0_rdata);
        next_cycle();
        idle();
    endtask

    task automatic test_p1_read();
        p0_req = 1; p0_we = 1; p0_addr = 32'h8; p0_wdata = 32'hA;
        next_cycle();
        p0_req = 0;
        p1_req = 1; p1_we = 0; p1_addr = 32'h8;
        #4;
        checks++; if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || p1_rvalid !== 1'b0) begin failures++; $display("FAIL p1_read_gnt got gnt=%b p0_gnt=%b rvalid=%b want 1 0 0", p1_gnt, p0_gnt, p1_rvalid); end
        next_cycle();
        p1_req = 0;
        #4;
        checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hA) begin failures++; $display("FAIL p1_read_data got rvalid=%b rdata=%h want 1 0000000a", p1_rvalid, p1_rdata); end
        $display("p1 read addr=8 data=%h", p1_rdata);
        next_cycle();
        #4;
        checks++; if (p1_rvalid !== 1'b0) begin failures++; $display("FAIL p1_read_pulse got rvalid=%b want 0", p1_rvalid); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        p1_req = 1; p1_we = 1; p1_addr = 32'hC; p1_wdata = 32'h0BADF00D;
        #4;
        checks++; if (p1_gnt !== 1'b1 || mem_WE !== 1'b1 || mem_WD !== 32'h0BADF00D) begin failures++; $display("FAIL p1_write got gnt=%b WE=%b WD=%h want 1 1 0badf00d", p1_gnt, mem_WE, mem_WD); end
        $display("p1 write addr=c data=0badf00d");
        next_cycle();
        p1_we = 0;
        #4;
        checks++; if (p1_rvalid !== 1'b0) begin failures++; $display("FAIL p1_write_norvalid got rvalid=%b want 0", p1_rvalid); end
        next_cycle();
        p1_addr = 32'h8;
        #4;
        checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'h0BADF00D) begin failures++; $display("FAIL b2b_first got rvalid=%b rdata=%h want 1 0badf00d", p1_rvalid, p1_rdata); end
        next_cycle();
        p1_req = 0;
        #4;
        checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hA) begin failures++; $display("FAIL b2b_second got rvalid=%b rdata=%h want 1 0000000a", p1_rvalid, p1_rdata); end
        $display("p1 back-to-back reads addr=c,8");
        next_cycle();
        #4;
        checks++; if (p1_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_end got rvalid=%b want 0", p1_rvalid); end
        next_cycle();
    endtask

    task automatic test_contention();
        logic e0, e1, f0, f1;
        p0_req = 1; p0_we = 0; p0_addr = 32'h0;
        p1_req = 1; p1_we = 0; p1_addr = 32'h8;
        for (int i = 0; i < 14; i++) begin
            #4;
            e1 = (i % 5 == 4);
            e0 = !e1;
            checks++; if (p0_gnt !== e0 || p1_gnt !== e1) begin failures++; $display("FAIL contention_l4 cyc=%0d got p0=%b p1=%b want %b %b", i, p0_gnt, p1_gnt, e0, e1); end
            if (i < 10) begin
                f1 = (i % 2 == 1);
                f0 = !f1;
                checks++; if (d1_p0_gnt !== f0 || d1_p1_gnt !== f1) begin failures++; $display("FAIL contention_l1 cyc=%0d got p0=%b p1=%b want %b %b", i, d1_p0_gnt, d1_p1_gnt, f0, f1); end
            end
            $display("contention cyc=%0d p0_gnt=%b p1_gnt=%b", i, p0_gnt, p1_gnt);
            next_cycle();
        end
        // Forced slot arrives but p1 withdrew: nobody is granted.
        p1_req = 0;
        #4;
        checks++; if (p0_gnt !== 1'b0 || p1_gnt !== 1'b0) begin failures++; $display("FAIL forced_drop got p0=%b p1=%b want 0 0", p0_gnt, p1_gnt); end
        next_cycle();
        #4;
        checks++; if (p0_gnt !== 1'b1) begin failures++; $display("FAIL forced_drop_after got p0=%b want 1", p0_gnt); end
        next_cycle();
        idle();
    endtask

    task automatic test_illegal();
        p0_req = 1; p0_we = 1; p0_addr = 32'h6; p0_wdata = 32'h12345678;
        #4;
        checks++; if (p0_gnt !== 1'b1 || mem_WE !== 1'b0) begin failures++; $display("FAIL misaligned_write got gnt=%b WE=%b want 1 0", p0_gnt, mem_WE); end
        next_cycle();
        p0_we = 0; p0_addr = 32'h12;
        #4;
        checks++; if (err !== 1'b1 || err_addr !== 32'h6) begin failures++; $display("FAIL err_first got err=%b addr=%h want 1 6", err, err_addr); end
        checks++; if (p0_gnt !== 1'b1 || p0_rdata !== 32'd0) begin failures++; $display("FAIL misaligned_read got gnt=%b rdata=%h want 1 0", p0_gnt, p0_rdata); end
        next_cycle();
        p0_req = 0;
        p1_req = 1; p1_we = 0; p1_addr = 32'd4000;
        #4;
        checks++; if (p1_gnt !== 1'b1) begin failures++; $display("FAIL range_read_gnt got %b want 1", p1_gnt); end
        next_cycle();
        p1_req = 0;
        #4;
        checks++; if (p1_rvalid !== 1'b1 || p1_rdata !== 32'd0) begin failures++; $display("FAIL range_read_data got rvalid=%b rdata=%h want 1 0", p1_rvalid, p1_rdata); end
        checks++; if (err !== 1'b1 || err_addr !== 32'h6) begin failures++; $display("FAIL err_sticky got err=%b addr=%h want 1 6", err, err_addr); end
        $display("illegal: err_addr=%h", err_addr);
        next_cycle();
    endtask

    task automatic test_reset_mid();
        logic e0, e1;
        // Build up p1 denials, then reset while the guard is about to fire.
        p0_req = 1; p0_we = 0; p0_addr = 32'h0;
        p1_req = 1; p1_we = 0; p1_addr = 32'h8;
        for (int i = 0; i < 3; i++) next_cycle();
        rst = 1;
        next_cycle();
        p0_req = 0;
        next_cycle();
        p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h55AA55AA;
        #4;
        checks++; if (p1_gnt !== 1'b1 || mem_WE !== 1'b0) begin failures++; $display("FAIL rst_write got gnt=%b WE=%b want 1 0", p1_gnt, mem_WE); end
        checks++; if (p1_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid_clear got %b want 0", p1_rvalid); end
        next_cycle();
        rst = 0; p1_req = 0;
        #4;
        checks++; if (env_mem[8] !== 32'd0) begin failures++; $display("FAIL rst_write_mem got %h want 0", env_mem[8]); end
        checks++; if (p1_rvalid !== 1'b0 || err !== 1'b0 || err_addr !== 32'd0) begin failures++; $display("FAIL rst_regs got rvalid=%b err=%b addr=%h want 0 0 0", p1_rvalid, err, err_addr); end
        $display("reset mid-operation: write suppressed");
        next_cycle();
        p0_req = 1; p1_req = 1; p1_we = 0; p1_addr = 32'h8;
        for (int i = 0; i < 5; i++) begin
            #4;
            e1 = (i == 4);
            e0 = !e1;
            checks++; if (p0_gnt !== e0 || p1_gnt !== e1) begin failures++; $display("FAIL rst_starve cyc=%0d got p0=%b p1=%b want %b %b", i, p0_gnt, p1_gnt, e0, e1); end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] model_mem [0:MEM_WORDS-1];
        int          run;
        bit          owed, err_m, rv_m, p0_pend, p1_pend, e0, e1, lg, ewe;
        logic [31:0] err_addr_m, rd_m, ea, ewd, ep0;

        for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = 32'd0;
        rst = 1; mem_clr = 1; p0_req = 0; p1_req = 0;
        next_cycle();
        rst = 0; mem_clr = 0;
        run = 0; owed = 0; err_m = 0; err_addr_m = 0; rv_m = 0; rd_m = 0;
        p0_pend = 0; p1_pend = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!p0_pend && $urandom_range(1, 0) == 1) begin
                p0_pend = 1; p0_we = 1'($urandom_range(1, 0)); p0_addr = rand_addr(); p0_wdata = $urandom;
            end
            if (!p1_pend && $urandom_range(1, 0) == 1) begin
                p1_pend = 1; p1_we = 1'($urandom_range(1, 0)); p1_addr = rand_addr(); p1_wdata = $urandom;
            end
            p0_req = p0_pend;
            p1_req = p1_pend;
            #4;

            e0 = 0; e1 = 0;
            if (owed) begin
                e1 = p1_req; owed = 0; run = 0;
            end else begin
                if (p0_req) e0 = 1;
                else if (p1_req) e1 = 1;
                if (p1_req && !e1) begin
                    run++;
                    if (run == 4) owed = 1;
                end else begin
                    run = 0;
                end
            end
            ea = e0 ? p0_addr : (e1 ? p1_addr : 32'd0);
            ewd = e0 ? p0_wdata : (e1 ? p1_wdata : 32'd0);
            lg = is_legal(ea);
            ewe = (e0 ? p0_we : (e1 ? p1_we : 1'b0)) && lg;
            ep0 = (e0 && lg) ? model_mem[ea[11:2]] : 32'd0;

            checks++; if (p0_gnt !== e0 || p1_gnt !== e1) begin failures++; $display("FAIL rand_gnt cyc=%0d got p0=%b p1=%b want %b %b", cyc, p0_gnt, p1_gnt, e0, e1); end
            checks++; if (mem_A !== ea || mem_WD !== ewd || mem_WE !== ewe) begin failures++; $display("FAIL rand_mem cyc=%0d got A=%h WD=%h WE=%b want %h %h %b", cyc, mem_A, mem_WD, mem_WE, ea, ewd, ewe); end
            checks++; if (p0_rdata !== ep0) begin failures++; $display("FAIL rand_p0_rdata cyc=%0d got %h want %h", cyc, p0_rdata, ep0); end
            checks++; if (p1_rvalid !== rv_m || p1_rdata !== rd_m) begin failures++; $display("FAIL rand_p1_resp cyc=%0d got rvalid=%b rdata=%h want %b %h", cyc, p1_rvalid, p1_rdata, rv_m, rd_m); end
            checks++; if (err !== err_m || err_addr !== err_addr_m) begin failures++; $display("FAIL rand_err cyc=%0d got err=%b addr=%h want %b %h", cyc, err, err_addr, err_m, err_addr_m); end
            if (e0 || e1)
                $display("rand cyc=%0d port=%0d we=%b addr=%h legal=%b", cyc, e1 ? 1 : 0, e0 ? p0_we : p1_we, ea, lg);

            if ((e0 || e1) && !lg && !err_m) begin
                err_m = 1; err_addr_m = ea;
            end
            rv_m = e1 && !p1_we;
            if (rv_m) rd_m = lg ? model_mem[ea[11:2]] : 32'd0;
            if (ewe) model_mem[ea[11:2]] = ewd;
            if (e0) p0_pend = 0;
            if (e1) p1_pend = 0;
            next_cycle();
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; mem_clr = 1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        #1;
        test_reset();
        test_p0_only();
        test_p1_read();
        test_back_to_back();
        test_contention();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
